// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package mips_ctrl_pkg;

    // Main FSM states; encodings 12..15 are unreachable and recover to fetch
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiExe = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    // ALU operation class handed from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        AluOpAdd   = 2'd0,
        AluOpSub   = 2'd1,
        AluOpFunct = 2'd2
    } alu_op_e;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU F encodings
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the ALUOp class and funct onto the ALU F input.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_e    i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_funct_illegal
);

    // Translate the operation class; unknown funct falls back to add and flags it
    always_comb begin
        o_alu_control   = ALU_ADD;
        o_funct_illegal = 1'b0;
        case (i_alu_op)
            AluOpAdd: o_alu_control = ALU_ADD;
            AluOpSub: o_alu_control = ALU_SUB;
            AluOpFunct: begin
                case (i_funct)
                    FUNCT_ADD: o_alu_control = ALU_ADD;
                    FUNCT_SUB: o_alu_control = ALU_SUB;
                    FUNCT_AND: o_alu_control = ALU_AND;
                    FUNCT_OR:  o_alu_control = ALU_OR;
                    FUNCT_SLT: o_alu_control = ALU_SLT;
                    default:   o_funct_illegal = 1'b1;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU decoder.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_J    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       illegal
);

    state_e     r_state;
    state_e     w_state_next;
    state_e     w_state_eff;
    alu_op_e    w_alu_op;
    logic       w_funct_illegal;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;

    alu_decoder u_alu_decoder (
        .i_alu_op        (w_alu_op),
        .i_funct         (funct),
        .o_alu_control   (alu_control),
        .o_funct_illegal (w_funct_illegal)
    );

    // State register with synchronous reset to fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // While reset is high the outputs decode as fetch so muxes sit at fetch values
    always_comb begin
        w_state_eff = reset ? StFetch : r_state;
    end

    // Next-state and output decode; every output defaults to its idle value
    always_comb begin
        w_state_next = StFetch;
        w_alu_op     = AluOpAdd;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        iord         = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        pc_src       = 2'b00;
        case (w_state_eff)
            StFetch: begin
                alu_src_b    = 2'b01;
                w_ir_write   = 1'b1;
                w_pc_write   = 1'b1;
                w_state_next = StDecode;
            end
            StDecode: begin
                // Branch target is computed here so it is waiting in ALUOut
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_state_next = StMemAdr;
                    OP_RTYPE:     w_state_next = StExecute;
                    OP_BEQ:       w_state_next = StBranch;
                    OP_ADDI: begin
                        if (ENABLE_ADDI) w_state_next = StAddiExe;
                        else             w_illegal    = 1'b1;
                    end
                    OP_J: begin
                        if (ENABLE_J) w_state_next = StJump;
                        else          w_illegal    = 1'b1;
                    end
                    default:      w_illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = (op == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord         = 1'b1;
                w_state_next = StMemWb;
            end
            StMemWb: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
            end
            StMemWr: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
            end
            StExecute: begin
                alu_src_a = 1'b1;
                w_alu_op  = AluOpFunct;
                if (w_funct_illegal) w_illegal    = 1'b1;
                else                 w_state_next = StAluWb;
            end
            StAluWb: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                w_alu_op  = AluOpSub;
                pc_src    = 2'b01;
                w_branch  = 1'b1;
            end
            StAddiExe: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = StAddiWb;
            end
            StAddiWb: begin
                w_reg_write = 1'b1;
            end
            StJump: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
            end
            default: w_state_next = StFetch;
        endcase
    end

    // Enables and the illegal pulse are suppressed while reset is asserted
    always_comb begin
        pc_en     = ~reset & (w_pc_write | (w_branch & zero));
        mem_write = ~reset & w_mem_write;
        ir_write  = ~reset & w_ir_write;
        reg_write = ~reset & w_reg_write;
        illegal   = ~reset & w_illegal;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for the multicycle MIPS control unit.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    int n_vec = 0;
    int n_err = 0;

    mips_multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Packed view of all outputs:
    // pc_en iord mem_write ir_write reg_dst mem_to_reg reg_write src_a src_b[2] alu[3] pc_src[2] ill
    logic [15:0] outs;
    assign outs = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, alu_control, pc_src, illegal};

    function automatic logic [15:0] mk(input logic pe, input logic io, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic [1:0] ps,
                                       input logic ill);
        return {pe, io, mw, irw, rd, m2r, rw, sa, sb, ac, ps, ill};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Compare outputs for the current cycle, then advance one clock
    task automatic cyc(input string tag, input logic [15:0] exp);
        #1;
        check_eq(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] e_rst, e_fetch, e_decode, e_dec_ill, e_memadr, e_memrd, e_memwb, e_memwr;
    logic [15:0] e_aluwb, e_addiexe, e_addiwb, e_jump;

    initial begin
        e_rst     = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0);
        e_fetch   = mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0);
        e_decode  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0);
        e_dec_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 1);
        e_memadr  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0);
        e_memrd   = mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0);
        e_memwb   = mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0);
        e_memwr   = mk(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0);
        e_aluwb   = mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0);
        e_addiexe = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0);
        e_addiwb  = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0);
        e_jump    = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 0);

        reset = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clk);
        #1;

        // Reset held, then a full lw
        cyc("rst0", e_rst);
        cyc("rst1", e_rst);
        cyc("rst2", e_rst);
        reset = 1'b0;
        cyc("lw_fetch", e_fetch);
        cyc("lw_decode", e_decode);
        cyc("lw_memadr", e_memadr);
        cyc("lw_memrd", e_memrd);
        cyc("lw_memwb", e_memwb);

        // R-type with each legal funct
        op = 6'b000000;
        funct = 6'b100000;
        cyc("add_fetch", e_fetch);
        cyc("add_decode", e_decode);
        cyc("add_exec", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0));
        cyc("add_wb", e_aluwb);
        funct = 6'b100010;
        cyc("sub_fetch", e_fetch);
        cyc("sub_decode", e_decode);
        cyc("sub_exec", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b00, 0));
        cyc("sub_wb", e_aluwb);
        funct = 6'b100100;
        cyc("and_fetch", e_fetch);
        cyc("and_decode", e_decode);
        cyc("and_exec", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 0));
        cyc("and_wb", e_aluwb);
        funct = 6'b100101;
        cyc("or_fetch", e_fetch);
        cyc("or_decode", e_decode);
        cyc("or_exec", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b00, 0));
        cyc("or_wb", e_aluwb);
        funct = 6'b101010;
        cyc("slt_fetch", e_fetch);
        cyc("slt_decode", e_decode);
        cyc("slt_exec", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 2'b00, 0));
        cyc("slt_wb", e_aluwb);

        // beq taken then not taken
        op = 6'b000100;
        zero = 1'b1;
        cyc("beq1_fetch", e_fetch);
        cyc("beq1_decode", e_decode);
        cyc("beq1_branch", mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0));
        zero = 1'b0;
        cyc("beq0_fetch", e_fetch);
        cyc("beq0_decode", e_decode);
        cyc("beq0_branch", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0));

        // sw
        op = 6'b101011;
        cyc("sw_fetch", e_fetch);
        cyc("sw_decode", e_decode);
        cyc("sw_memadr", e_memadr);
        cyc("sw_memwr", e_memwr);

        // addi
        op = 6'b001000;
        cyc("addi_fetch", e_fetch);
        cyc("addi_decode", e_decode);
        cyc("addi_exe", e_addiexe);
        cyc("addi_wb", e_addiwb);

        // Illegal opcode, then illegal funct
        op = 6'b111111;
        cyc("ilop_fetch", e_fetch);
        cyc("ilop_decode", e_dec_ill);
        op = 6'b000000;
        funct = 6'b000111;
        cyc("ilfn_fetch", e_fetch);
        cyc("ilfn_decode", e_decode);
        cyc("ilfn_exec", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 1));

        // lw interrupted by reset in MEMRD, then j
        op = 6'b100011;
        cyc("lwr_fetch", e_fetch);
        cyc("lwr_decode", e_decode);
        cyc("lwr_memadr", e_memadr);
        reset = 1'b1;
        cyc("lwr_reset", e_rst);
        reset = 1'b0;
        op = 6'b000010;
        cyc("j_fetch", e_fetch);
        cyc("j_decode", e_decode);
        cyc("j_jump", e_jump);
        cyc("j_after", e_fetch);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
